uart_cmd_decode: RTL
====================

# uart_cmd_decode

Byte-stream command decoder sitting directly downstream of `uart_rx`. It consumes the received byte and its one-cycle valid strobe, and recognises write and read frames. Write payload bytes are forwarded to the SDRAM write-FIFO. Single-cycle triggers are issued to the SDRAM controller front end; `uart_tx` loopback is no longer driven directly by `rx_data`.

## Interface
- `WR_LEN`, default 4: payload bytes per write frame (1..255).
- `TIMEOUT`, default 50000: maximum idle clock cycles allowed between bytes inside a frame before the frame is aborted (≥2).

One clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock (PLL `c0`).
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  byte from `uart_rx`; valid only while `po_flag`=1.
- `po_flag`  in  1  one-cycle byte-valid strobe from `uart_rx`.
- `wfifo_wr_en`  out  1  write strobe to the SDRAM write FIFO.
- `wfifo_wr_data`  out  8  payload byte; valid with `wfifo_wr_en`.
- `wfifo_clr`  out  1  one-cycle pulse requesting a FIFO flush after an aborted write frame.
- `wr_trig`  out  1  one-cycle pulse: a complete write frame is in the FIFO.
- `rd_trig`  out  1  one-cycle pulse: read command received.
- `frame_err`  out  1  one-cycle pulse: bad command byte or timeout.
- `busy`  out  1  high while state ≠ IDLE.

## Operation
- Frame formats:
  - Write: 0x55, 0xAA, then exactly `WR_LEN` payload bytes.
  - Read: 0x55, 0xA5.
- States: IDLE, CMD, DATA.
  - IDLE:
    - `po_flag` with 0x55 → CMD.
    - Any other byte is ignored silently; no error is raised.
  - CMD:
    - 0xAA → DATA, with the byte counter cleared to 0.
    - 0xA5 → pulse `rd_trig`, → IDLE.
    - Any other value, including 0x55 → pulse `frame_err`, → IDLE.
  - DATA:
    - Each `po_flag` → `wfifo_wr_en`=1 and `wfifo_wr_data`=`rx_data`; counter increments.
    - When the counter reaches `WR_LEN` → pulse `wr_trig`, → IDLE.
    - Payload bytes are not interpreted; 0x55 is ordinary data here.
- Timeout counter:
  - Cleared on every `po_flag` and whenever in IDLE.
  - Increments each cycle in CMD/DATA.
  - On reaching `TIMEOUT`-1 → pulse `frame_err`, → IDLE.
  - If the abort happens in DATA with counter > 0, also pulse `wfifo_clr` in the same cycle as `frame_err`.
- Widths:
  - Byte counter is 8 bits and compares equal to `WR_LEN`.
  - Timeout counter is `$clog2(TIMEOUT)` bits and never wraps (saturates via the abort).
- Simultaneous events: a `po_flag` arriving in the same cycle the timeout fires takes priority. The byte is processed normally and the timeout counter clears; no error is raised.
- Reset, including mid-frame: all outputs 0, state IDLE, both counters 0.
  - Bytes already written to the FIFO are not flushed by reset; the FIFO has its own reset.

## Timing
- All outputs are registered; none is combinational from inputs.
- Reset values: `wfifo_wr_en`=0, `wfifo_wr_data`=0x00, `wfifo_clr`=0, `wr_trig`=0, `rd_trig`=0, `frame_err`=0, `busy`=0.
- Latencies, with `po_flag` at cycle N:
  - State update visible at N+1; `busy` rises at N+1 after the 0x55 header.
  - `rd_trig` / `frame_err` (bad command) at N+1.
  - `wfifo_wr_en` / `wfifo_wr_data` at N+1.
  - `wr_trig` for the last payload byte at N+2, one cycle after its `wfifo_wr_en`, so the FIFO count already includes it.
  - `busy` falls in the cycle `wr_trig` is high.
- Timeout: with the last `po_flag` at cycle N, `frame_err` is asserted at N+`TIMEOUT`.
- Back-to-back bytes: `po_flag` on consecutive cycles is accepted with no loss; each yields its own `wfifo_wr_en`.
- Every pulse output is exactly one cycle wide.

## Test plan
- Reset, then write frame 0x55 0xAA 0x11 0x22 0x33 0x44 with `WR_LEN`=4 → four `wfifo_wr_en` pulses carrying 0x11, 0x22, 0x33, 0x44; `wr_trig` one cycle after the 0x44 write; no `frame_err`.
- Read frame 0x55 0xA5 → `rd_trig` one cycle after the 0xA5 strobe; `wfifo_wr_en` never asserted.
- Bytes 0x00 0x12 then 0x55 0x3C → nothing for the first two bytes; `frame_err` one cycle after 0x3C; `busy` returns to 0.
- With `TIMEOUT`=20, send 0x55 0xAA 0x01 then stop → `frame_err` and `wfifo_clr` 20 cycles after the 0x01 strobe. A following 0x55 0xA5 then yields `rd_trig` normally.
- Write frame with payload 0x55 0xAA 0x55 0xAA, strobes on consecutive cycles → all four bytes forwarded in order, then `wr_trig`.
- Assert `rst` after the second payload byte → all outputs 0 immediately. After release, 0x55 0xA5 → `rd_trig`.

Source files
------------

// File: rtl/uart_cmd_decode.sv
// Byte-stream command decoder behind uart_rx: recognises 0x55 0xAA <payload> write
// frames and 0x55 0xA5 read frames, forwarding payload to the SDRAM write FIFO.
module uart_cmd_decode #(
  parameter int unsigned WR_LEN  = 4,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       po_flag,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_wr_data,
  output logic       wfifo_clr,
  output logic       wr_trig,
  output logic       rd_trig,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned    TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]     LEN     = 8'(WR_LEN);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t        state_q, state_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d, to_inc;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          clr_q, clr_d;
  logic          wr_trig_q, wr_trig_d;
  logic          rd_trig_q, rd_trig_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    to_inc     = to_cnt_q + 1'b1;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    clr_d      = 1'b0;
    wr_trig_d  = 1'b0;
    rd_trig_d  = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (po_flag && rx_data == 8'h55) state_d = CMD;
      end
      CMD: begin
        if (po_flag) begin
          to_cnt_d = '0;
          if (rx_data == 8'hAA) begin
            state_d    = DATA;
            byte_cnt_d = 8'd0;
          end else begin
            if (rx_data == 8'hA5) rd_trig_d = 1'b1;
            else                  err_d     = 1'b1;
            state_d = IDLE;
          end
        end else if (to_inc == TO_LAST) begin
          err_d    = 1'b1;
          to_cnt_d = '0;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_inc;
        end
      end
      DATA: begin
        // Completion is one cycle after the last write so the FIFO count includes it.
        if (byte_cnt_q == LEN) begin
          wr_trig_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = (po_flag && rx_data == 8'h55) ? CMD : IDLE;
        end else if (po_flag) begin
          wr_en_d    = 1'b1;
          wr_data_d  = rx_data;
          byte_cnt_d = byte_cnt_q + 8'd1;
          to_cnt_d   = '0;
        end else if (to_inc == TO_LAST) begin
          err_d    = 1'b1;
          clr_d    = (byte_cnt_q != 8'd0);
          to_cnt_d = '0;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= 8'd0;
      to_cnt_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'h00;
      clr_q      <= 1'b0;
      wr_trig_q  <= 1'b0;
      rd_trig_q  <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      clr_q      <= clr_d;
      wr_trig_q  <= wr_trig_d;
      rd_trig_q  <= rd_trig_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign wfifo_wr_en   = wr_en_q;
  assign wfifo_wr_data = wr_data_q;
  assign wfifo_clr     = clr_q;
  assign wr_trig       = wr_trig_q;
  assign rd_trig       = rd_trig_q;
  assign frame_err     = err_q;
  assign busy          = busy_q;

endmodule
